activity_monitor: RTL and testbench
===================================

// Module: activity_monitor
// PURPOSE
//  N-channel activity detector for the board top level: drives the disk/download LED,
//  latches virtual-SD select and stretches the core reset on image mount.
//  Watches toggles on SPI-style lines and explicit strobes (ioctl_download etc.).
//  Each channel has a retriggerable hold timer; a single active-low LED output results.
//  Sits beside mist_io / sd_card; all logic on clk_sys.
// PARAMETERS
//  CHANNELS    4         number of monitored channels
//  SIG_W       2         toggle-watched lines per channel (e.g. mosi, miso)
//  HOLD_CYCLES 1000000   cycles act_o stays high after the last event (>=1)
//  RST_CYCLES  10000000  reset_req_o length after a mount strobe (>=1)
//  BLINK_W     22        blink divider width (used only with ACT_LED_BLINK_EN)
// PORTS
//  clk_sys      in   1                 system clock
//  reset        in   1                 synchronous, active-high reset
//  sig_i        in   CHANNELS*SIG_W    monitored lines; ch c owns [c*SIG_W +: SIG_W]
//  pulse_i      in   CHANNELS          level/strobe activity, ch c = bit c
//  led_mask_i   in   CHANNELS          1 = channel contributes to the LED
//  mount_i      in   1                 image-mounted strobe
//  mount_nz_i   in   1                 image size nonzero, sampled with mount_i
//  act_o        out  CHANNELS          per-channel activity
//  any_act_o    out  1                 |(act_o & led_mask_i)
//  led_n_o      out  1                 active-low LED drive
//  sel_o        out  1                 latched virtual-SD select
//  reset_req_o  out  1                 stretched reset request to core COLD_RESET
// BEHAVIOUR
//  Reset (sync, one cycle sufficient): prev<=sig_i, cnt<=HOLD_CYCLES, rcnt<=0, sel_o<=0,
//   blink<=0. Hence act_o=0, any_act_o=0, led_n_o=1, reset_req_o=0. sig_i changes
//   during reset never produce activity.
//  Per channel, each edge: prev<=sig_i; ev = |(sig_i^prev) | pulse_i[c].
//   ev -> cnt<=0; else if cnt<HOLD_CYCLES -> cnt<=cnt+1; saturates at HOLD_CYCLES.
//   act_o[c] = (cnt != HOLD_CYCLES), decoded from the register.
//   Latency: event sampled at edge k -> act_o high after edge k. act_o low after edge
//   k+HOLD_CYCLES if no further event. High for exactly HOLD_CYCLES cycles.
//   A new event while active restarts the hold. A held pulse_i keeps act_o high.
//  cnt width = $clog2(HOLD_CYCLES+1); no wrap, saturation only.
//  Mount: mount_i at edge -> sel_o<=mount_nz_i, rcnt<=RST_CYCLES.
//   Else if rcnt!=0 -> rcnt<=rcnt-1. reset_req_o = (rcnt!=0).
//   reset_req_o is high for RST_CYCLES cycles starting the cycle after the strobe.
//   A mount during the stretch restarts the count and re-latches sel_o.
//   Held mount_i keeps reset_req_o high.
//  Reset asserted mid-hold or mid-stretch aborts immediately; outputs take reset values.
//  Channels are independent; simultaneous events on all channels are legal.
// CONFIGURATION
//  ACT_LED_BLINK_EN defined:
//   - blink counter free-runs (BLINK_W bits; cleared by reset).
//   - led_n_o = ~(any_act_o & blink[BLINK_W-1]); LED flashes while active.
//  ACT_LED_BLINK_EN undefined:
//   - no blink counter.
//   - led_n_o = ~any_act_o; LED is steady on while active.
// STRUCTURE
//  act_monitor_pkg: default parameter constants.
//  act_monitor_pkg: function cnt_width(n) = $clog2(n+1).
//  Sub-module act_channel (prev register, hold counter, act decode).
//  act_channel is instantiated CHANNELS times via generate.
//  Mount/reset stretcher and LED logic live in activity_monitor itself.
// TESTING  (CHANNELS=4, SIG_W=2, HOLD_CYCLES=8, RST_CYCLES=5, BLINK_W=3)
//  1 reset 4 cycles while sig_i toggles every cycle, mount_i=1 ->
//    act_o=0, led_n_o=1, reset_req_o=0, sel_o=0 throughout.
//    No activity on release with sig_i static.
//  2 toggle sig_i[1] once at edge 10 -> act_o=4'b0001 after edges 10..17.
//    act_o=0 after edge 18. led_n_o mirrors (no blink). Other channels stay 0.
//  3 toggles ch0 at edges 10 and 15 -> act_o[0] high through edge 22, low after 23.
//    pulse_i[2] high edges 30..32 -> act_o[2] high until edge 32+8.
//  4 led_mask_i=4'b1110, activity ch0 only -> act_o[0]=1, any_act_o=0, led_n_o=1.
//  5 mount_i at edge 5, mount_nz_i=1 -> sel_o=1 and reset_req_o=1 after edge 5..9.
//    Second mount at edge 7 with mount_nz_i=0 -> sel_o=0, reset_req_o high until edge 12.
//  6 reset at edge 4 of a hold and of a stretch -> all outputs to reset values next edge.
//    With ACT_LED_BLINK_EN: during activity led_n_o toggles every 4 cycles.

Source files
------------

// File: rtl/act_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : act_monitor_pkg
//  Brief    : Default parameters and width helper for activity_monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package act_monitor_pkg;

    localparam int c_default_channels    = 4;
    localparam int c_default_sig_w       = 2;
    localparam int c_default_hold_cycles = 1000000;
    localparam int c_default_rst_cycles  = 10000000;
    localparam int c_default_blink_w     = 22;

    // Width able to hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_channel.sv
`default_nettype none
// ============================================================================
//  Module   : act_channel
//  Brief    : One activity channel - edge detect on watched lines plus strobe,
//             retriggerable saturating hold counter, activity decode.
//  Revision : 1.0 - initial release
// ============================================================================
module act_channel
    import act_monitor_pkg::*;
#(
    parameter int SIG_W       = c_default_sig_w,
    parameter int HOLD_CYCLES = c_default_hold_cycles
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [SIG_W-1:0] sig_i,
    input  logic             pulse_i,
    output logic             act_o
);

    localparam int                 c_cnt_w = cnt_width(HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_hold  = c_cnt_w'(HOLD_CYCLES);

    logic [SIG_W-1:0]   r_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_ev;

    assign w_ev = (|(sig_i ^ r_prev)) | pulse_i;

    // Reset loads prev from the live lines so toggles during reset leave no trace.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_prev <= sig_i;
            r_cnt  <= c_hold;
        end else begin
            r_prev <= sig_i;
            if (w_ev) begin
                r_cnt <= '0;
            end else if (r_cnt < c_hold) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign act_o = (r_cnt != c_hold);

endmodule
`default_nettype wire

// File: rtl/activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : activity_monitor
//  Brief    : N-channel activity detector driving the disk LED, latching the
//             virtual-SD select and stretching core reset on image mount.
//             Optional macro ACT_LED_BLINK_EN: LED flashes while active.
//  Revision : 1.0 - initial release
// ============================================================================
module activity_monitor
    import act_monitor_pkg::*;
#(
    parameter int CHANNELS    = c_default_channels,
    parameter int SIG_W       = c_default_sig_w,
    parameter int HOLD_CYCLES = c_default_hold_cycles,
    parameter int RST_CYCLES  = c_default_rst_cycles,
    parameter int BLINK_W     = c_default_blink_w
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS*SIG_W-1:0] sig_i,
    input  logic [CHANNELS-1:0]       pulse_i,
    input  logic [CHANNELS-1:0]       led_mask_i,
    input  logic                      mount_i,
    input  logic                      mount_nz_i,
    output logic [CHANNELS-1:0]       act_o,
    output logic                      any_act_o,
    output logic                      led_n_o,
    output logic                      sel_o,
    output logic                      reset_req_o
);

    localparam int                  c_rcnt_w = cnt_width(RST_CYCLES);
    localparam logic [c_rcnt_w-1:0] c_rst    = c_rcnt_w'(RST_CYCLES);

    logic [CHANNELS-1:0] w_act;
    logic [c_rcnt_w-1:0] r_rcnt;
    logic                r_sel;
    logic                w_any_act;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        act_channel #(
            .SIG_W      (SIG_W),
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_act_channel (
            .clk_sys(clk_sys),
            .reset  (reset),
            .sig_i  (sig_i[g*SIG_W +: SIG_W]),
            .pulse_i(pulse_i[g]),
            .act_o  (w_act[g])
        );
    end

    // A mount strobe (re)starts the stretch and re-latches the select.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rcnt <= '0;
            r_sel  <= 1'b0;
        end else if (mount_i) begin
            r_rcnt <= c_rst;
            r_sel  <= mount_nz_i;
        end else if (r_rcnt != '0) begin
            r_rcnt <= r_rcnt - 1'b1;
        end
    end

    assign w_any_act   = |(w_act & led_mask_i);
    assign act_o       = w_act;
    assign any_act_o   = w_any_act;
    assign sel_o       = r_sel;
    assign reset_req_o = (r_rcnt != '0);

`ifdef ACT_LED_BLINK_EN
    logic [BLINK_W-1:0] r_blink;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    assign led_n_o = ~(w_any_act & r_blink[BLINK_W-1]);
`else
    assign led_n_o = ~w_any_act;
`endif

endmodule
`default_nettype wire

// File: tb/tb_activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_activity_monitor
//  Brief    : Directed self-checking bench for activity_monitor (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_activity_monitor;

    localparam int CHANNELS    = 4;
    localparam int SIG_W       = 2;
    localparam int HOLD_CYCLES = 8;
    localparam int RST_CYCLES  = 5;
    localparam int BLINK_W     = 3;

    logic                      clk_sys = 1'b0;
    logic                      reset;
    logic [CHANNELS*SIG_W-1:0] sig_i;
    logic [CHANNELS-1:0]       pulse_i;
    logic [CHANNELS-1:0]       led_mask_i;
    logic                      mount_i;
    logic                      mount_nz_i;
    logic [CHANNELS-1:0]       act_o;
    logic                      any_act_o;
    logic                      led_n_o;
    logic                      sel_o;
    logic                      reset_req_o;

    int total = 0;
    int bad   = 0;

    activity_monitor #(
        .CHANNELS   (CHANNELS),
        .SIG_W      (SIG_W),
        .HOLD_CYCLES(HOLD_CYCLES),
        .RST_CYCLES (RST_CYCLES),
        .BLINK_W    (BLINK_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .sig_i      (sig_i),
        .pulse_i    (pulse_i),
        .led_mask_i (led_mask_i),
        .mount_i    (mount_i),
        .mount_nz_i (mount_nz_i),
        .act_o      (act_o),
        .any_act_o  (any_act_o),
        .led_n_o    (led_n_o),
        .sel_o      (sel_o),
        .reset_req_o(reset_req_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".act"},   32'(act_o),       32'h0);
        check({tag, ".any"},   32'(any_act_o),   32'h0);
        check({tag, ".led"},   32'(led_n_o),     32'h1);
        check({tag, ".req"},   32'(reset_req_o), 32'h0);
        check({tag, ".sel"},   32'(sel_o),       32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        sig_i      = '0;
        pulse_i    = '0;
        led_mask_i = 4'b1111;
        mount_i    = 1'b1;
        mount_nz_i = 1'b1;

        // 1: reset with toggling lines and mount held
        for (int i = 0; i < 4; i++) begin
            sig_i = ~sig_i;
            tick();
            check_idle("rst_hold");
        end
        reset   = 1'b0;
        mount_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("rst_release");
        end

        // 2: single toggle on sig_i[1] (channel 0)
        sig_i[1] = ~sig_i[1];
        for (int i = 0; i < 9; i++) begin
            tick();
            check("single.act", 32'(act_o),   (i < 8) ? 32'h1 : 32'h0);
            check("single.led", 32'(led_n_o), (i < 8) ? 32'h0 : 32'h1);
        end

        // 3a: retrigger on channel 0 five edges after the first toggle
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || i == 5) sig_i[0] = ~sig_i[0];
            tick();
            check("retrig.act", 32'(act_o), (i <= 12) ? 32'h1 : 32'h0);
        end

        // 3b: pulse_i[2] held for three edges
        for (int i = 0; i < 12; i++) begin
            pulse_i[2] = (i < 3);
            tick();
            check("pulse.act", 32'(act_o), (i <= 9) ? 32'h4 : 32'h0);
        end
        pulse_i = '0;

        // 4: masked channel does not light the LED, unmasked one does
        led_mask_i = 4'b1110;
        sig_i[0]   = ~sig_i[0];
        tick();
        check("mask.act", 32'(act_o),     32'h1);
        check("mask.any", 32'(any_act_o), 32'h0);
        check("mask.led", 32'(led_n_o),   32'h1);
        sig_i[3] = ~sig_i[3];
        tick();
        check("mask2.act", 32'(act_o),     32'h3);
        check("mask2.any", 32'(any_act_o), 32'h1);
        check("mask2.led", 32'(led_n_o),   32'h0);
        for (int i = 0; i < 10; i++) tick();
        check("mask_idle.act", 32'(act_o), 32'h0);
        led_mask_i = 4'b1111;

        // 5: mount, then re-mount during the stretch with size zero
        for (int i = 0; i < 9; i++) begin
            mount_i    = (i == 0 || i == 2);
            mount_nz_i = (i == 0);
            tick();
            check("mount.sel", 32'(sel_o),       (i < 2)  ? 32'h1 : 32'h0);
            check("mount.req", 32'(reset_req_o), (i <= 6) ? 32'h1 : 32'h0);
        end
        mount_i = 1'b0;

        // 6: reset aborts an in-flight hold and stretch
        sig_i[4]   = ~sig_i[4];
        mount_i    = 1'b1;
        mount_nz_i = 1'b1;
        tick();
        mount_i = 1'b0;
        check("abort_pre.act", 32'(act_o),       32'h4);
        check("abort_pre.req", 32'(reset_req_o), 32'h1);
        check("abort_pre.sel", 32'(sel_o),       32'h1);
        for (int i = 0; i < 3; i++) tick();
        check("abort_mid.act", 32'(act_o),       32'h4);
        check("abort_mid.req", 32'(reset_req_o), 32'h1);
        reset = 1'b1;
        tick();
        check_idle("abort");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("abort_after");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
